// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Contents : State encodings, owner codes and default widths shared by the
//            memory port arbiter and its starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 30;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_starve_counter.sv
// ============================================================================
// Module   : arb_starve_counter
// Contents : Saturating count of arbitrations lost by IF; raises force_o once
//            the count reaches MAX_WAIT (MAX_WAIT must be >= 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import mem_arb_pkg::*;

module arb_starve_counter #(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic force_o
);

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Contents : Shares one variable-latency single-ported memory between fetch
//            (IF) and load/store (D); D wins ties. Optional IF anti-starvation
//            is enabled by defining STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              we_q,        we_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q,  d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

  logic w_idle;
  logic w_busy;
  logic w_done;
  logic w_owner;
  logic w_force_if;
  logic w_grant_if;
  logic w_grant_d;

  assign w_idle  = (state_q == ST_IDLE);
  assign w_busy  = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_D);
  assign w_done  = w_busy && mem_ready;
  assign w_owner = (state_q == ST_BUSY_D) ? OWNER_D : OWNER_IF;

  // IF takes the slot when D is absent, or when the starvation guard forces it.
  assign w_grant_if = w_idle && if_req && (!d_req || w_force_if);
  assign w_grant_d  = w_idle && d_req && !w_grant_if;

`ifdef STARVE_GUARD_EN
  arb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (w_grant_d && if_req),
    .clr_i   (w_grant_if),
    .force_o (w_force_if)
  );
`else
  // Strict D priority: the force condition is constant false.
  assign w_force_if = (MAX_WAIT < 0);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    if (w_grant_d) begin
      state_d = ST_BUSY_D;
      addr_d  = d_addr;
      we_d    = d_we;
      wdata_d = d_wdata;
    end else if (w_grant_if) begin
      state_d = ST_BUSY_IF;
      addr_d  = if_addr;
      we_d    = 1'b0;
    end else if (w_done) begin
      state_d = ST_IDLE;
      if (w_owner == OWNER_D) begin
        d_rvalid_d = 1'b1;
        if (!we_q) begin
          d_rdata_d = mem_rdata;
        end
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata;
      end
    end else if (!w_busy) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = w_grant_if;
  assign d_gnt     = w_grant_d;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = w_busy;
  assign mem_we    = w_busy && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Contents : Directed scoreboard bench for mem_port_arbiter; read data is
//            checked by a monitor against queued expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  logic [31:0] mon_e;

  mem_port_arbiter #(
    .ADDR_W   (30),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Memory model: read data is the word address XOR a fixed tag.
  assign mem_rdata = {2'b00, mem_addr} ^ 32'hCAFE_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (if_rvalid) begin
      if (exp_if.size() == 0) begin
        chk("if_rvalid_unexpected", if_rvalid, 1'b0);
      end else begin
        mon_e = exp_if.pop_front();
        chk("if_rdata", if_rdata, mon_e);
      end
    end
    if (d_rvalid) begin
      if (exp_d.size() == 0) begin
        chk("d_rvalid_unexpected", d_rvalid, 1'b0);
      end else begin
        mon_e = exp_d.pop_front();
        chk("d_rdata", d_rdata, mon_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int ni;
    int d_at_first_if;

    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;

    mid();
    chk("reset_outputs",
        {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we},
        '0);
    chk("reset_mem_bus", {mem_addr, mem_wdata}, '0);

    // Test 1: single fetch, memory ready every cycle
    next_cycle();
    reset     = 1'b0;
    mem_ready = 1'b1;
    if_req    = 1'b1;
    if_addr   = 30'h100000;
    mid();
    chk("t1_if_gnt", if_gnt, 1'b1);
    chk("t1_d_gnt", d_gnt, 1'b0);
    exp_if.push_back(32'hCAEE_0000);
    next_cycle();
    if_req = 1'b0;
    mid();
    chk("t1_mem_en_we", {mem_en, mem_we}, 2'b10);
    chk("t1_mem_addr", mem_addr, 30'h100000);
    chk("t1_if_rvalid_early", if_rvalid, 1'b0);
    next_cycle();
    mid();
    chk("t1_if_rvalid", if_rvalid, 1'b1);
    chk("t1_mem_en_idle", mem_en, 1'b0);

    // Test 2: simultaneous requests, D load wins
    next_cycle();
    if_req  = 1'b1;
    if_addr = 30'h200;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 30'h1000;
    mid();
    chk("t2_d_gnt_first", {d_gnt, if_gnt}, 2'b10);
    exp_d.push_back(32'hCAFE_1000);
    next_cycle();
    d_req = 1'b0;
    mid();
    chk("t2_mem_addr_d", {mem_en, mem_addr}, {1'b1, 30'h1000});
    chk("t2_if_gnt_busy", if_gnt, 1'b0);
    next_cycle();
    mid();
    chk("t2_if_gnt_on_rvalid", {d_rvalid, if_gnt}, 2'b11);
    exp_if.push_back(32'hCAFE_0200);
    next_cycle();
    if_req = 1'b0;
    mid();
    chk("t2_mem_addr_if", {mem_en, mem_we, mem_addr}, {2'b10, 30'h200});
    next_cycle();
    mid();
    chk("t2_if_rvalid", if_rvalid, 1'b1);

    // Test 3: store with three-cycle memory latency
    next_cycle();
    mem_ready = 1'b0;
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 30'h0ABC;
    d_wdata   = 32'h1234_5678;
    mid();
    chk("t3_d_gnt", d_gnt, 1'b1);
    exp_d.push_back(32'hCAFE_1000);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      d_req = 1'b0;
      if (i == 3) mem_ready = 1'b1;
      mid();
      chk("t3_mem_stable", {mem_en, mem_we, mem_addr, mem_wdata},
          {2'b11, 30'h0ABC, 32'h1234_5678});
      chk("t3_no_early_rvalid", d_rvalid, 1'b0);
    end
    next_cycle();
    mid();
    chk("t3_d_rvalid", {d_rvalid, mem_en, mem_we}, 3'b100);
    next_cycle();
    mid();
    chk("t3_d_rvalid_once", d_rvalid, 1'b0);
    chk("t3_d_rdata_held", d_rdata, 32'hCAFE_1000);

    // Test 4: reset in the middle of a D load
    next_cycle();
    mem_ready = 1'b0;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 30'h55;
    mid();
    chk("t4_d_gnt", d_gnt, 1'b1);
    next_cycle();
    d_req = 1'b0;
    mid();
    chk("t4_mem_en_busy", mem_en, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_mem_en_async_drop", mem_en, 1'b0);
    next_cycle();
    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("t4_no_rvalid", {d_rvalid, mem_en}, 2'b00);
      next_cycle();
    end
    d_req  = 1'b1;
    d_addr = 30'h77;
    mid();
    chk("t4_regrant", d_gnt, 1'b1);
    exp_d.push_back(32'hCAFE_0077);
    next_cycle();
    d_req = 1'b0;
    mid();
    chk("t4_regrant_mem", {mem_en, mem_addr}, {1'b1, 30'h77});
    next_cycle();
    mid();
    chk("t4_regrant_rvalid", d_rvalid, 1'b1);

    // Test 5: both ports requesting continuously
    next_cycle();
    if_req        = 1'b1;
    if_addr       = 30'h400;
    d_req         = 1'b1;
    d_we          = 1'b0;
    d_addr        = 30'h300;
    nd            = 0;
    ni            = 0;
    d_at_first_if = -1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) next_cycle();
      mid();
      chk("t5_onehot_gnt", d_gnt && if_gnt, 1'b0);
      if (d_gnt) begin
        nd++;
        exp_d.push_back(32'hCAFE_0300);
      end
      if (if_gnt) begin
        if (ni == 0) d_at_first_if = nd;
        ni++;
        exp_if.push_back(32'hCAFE_0400);
      end
    end
    next_cycle();
    if_req = 1'b0;
    d_req  = 1'b0;
`ifdef STARVE_GUARD_EN
    chk("t5_d_grants_before_if", d_at_first_if, 4);
    chk("t5_if_grants", ni, 2);
    chk("t5_d_grants", nd, 8);
`else
    chk("t5_if_starved", ni, 0);
    chk("t5_d_grants", nd, 10);
`endif

    for (int i = 0; i < 4; i++) next_cycle();
    mid();
    chk("drain_if_queue", exp_if.size(), 0);
    chk("drain_d_queue", exp_d.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
